// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the FIR tap sequencer.
package fir_pkg;
  localparam int TAP_NUM  = 10;
  localparam int SAMPLE_W = 3;
  localparam int MAC_W    = 16;
  localparam int DELAY_W  = 30;
  localparam int COEFF_AW = 4;
  localparam int OVR_W    = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, RUN, CAPTURE} state_e;
endpackage

// File: rtl/fir_delay_chain.sv
// Sample delay line: newest sample enters the low bits, oldest falls off the top.
module fir_delay_chain #(
  parameter int TAPS = fir_pkg::TAP_NUM,
  parameter int SW   = fir_pkg::SAMPLE_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               shift_en_i,
  input  logic [SW-1:0]      sample_i,
  output logic [TAPS*SW-1:0] chain_o
);
  logic [TAPS*SW-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)           chain_q <= '0;
    else if (shift_en_i) chain_q <= {chain_q[TAPS*SW-SW-1:0], sample_i};
  end

  assign chain_o = chain_q;
endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: shifts in a sample, walks the coefficient SRAM / MAC for
// TAP_NUM+1 cycles, then captures the MAC result. Optional FIR_OVERRUN_CNT_EN
// adds a saturating count of strobes dropped while busy.
module fir_tap_sequencer #(
  parameter int TAP_NUM  = fir_pkg::TAP_NUM,
  parameter int SAMPLE_W = fir_pkg::SAMPLE_W,
  parameter int MAC_W    = fir_pkg::MAC_W
) (
  input  logic                        iClk12M,
  input  logic                        iRst,
  input  logic                        iEnSample,
  input  logic [SAMPLE_W-1:0]         iFirIn,
  output logic [TAP_NUM*SAMPLE_W-1:0] oDelay,
  output logic                        oCsn,
  output logic [fir_pkg::COEFF_AW-1:0] oAddr,
  output logic                        oEnMul,
  output logic                        oEnAddAcc,
  input  logic [MAC_W-1:0]            iMac,
`ifdef FIR_OVERRUN_CNT_EN
  output logic [fir_pkg::OVR_W-1:0]   oOverrun,
`endif
  output logic [MAC_W-1:0]            oFirOut,
  output logic                        oValid,
  output logic                        oBusy
);
  import fir_pkg::*;

  localparam logic [COEFF_AW-1:0] LAST_CNT = COEFF_AW'(TAP_NUM);
  localparam logic [COEFF_AW-1:0] CSN_OFF  = COEFF_AW'(TAP_NUM - 1);

  state_e                state_q;
  logic [COEFF_AW-1:0]   cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]   sample_q;
  logic [MAC_W-1:0]      fir_q;
  logic                  valid_q, mul_q, csn_q, busy_q;
  logic [COEFF_AW-1:0]   addr_q;

  assign cnt_d = cnt_q + COEFF_AW'(1);

  // Outputs are registered from the next state, so oAddr runs one tap ahead
  // of the MAC to cover the SRAM read latency.
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sample_q <= '0;
      fir_q    <= '0;
      valid_q  <= 1'b0;
      mul_q    <= 1'b0;
      csn_q    <= 1'b1;
      addr_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (iEnSample) begin
          state_q  <= SHIFT;
          sample_q <= iFirIn;
          addr_q   <= '0;
          csn_q    <= 1'b0;
          busy_q   <= 1'b1;
        end
        SHIFT: begin
          state_q <= RUN;
          cnt_q   <= '0;
          mul_q   <= 1'b1;
          addr_q  <= COEFF_AW'(1);
          csn_q   <= 1'b0;
        end
        RUN: if (cnt_q == LAST_CNT) begin
          state_q <= CAPTURE;
          cnt_q   <= '0;
          mul_q   <= 1'b0;
          csn_q   <= 1'b1;
          addr_q  <= '0;
        end else begin
          cnt_q  <= cnt_d;
          addr_q <= cnt_d + COEFF_AW'(1);
          csn_q  <= (cnt_d >= CSN_OFF);
        end
        CAPTURE: begin
          state_q <= IDLE;
          fir_q   <= iMac;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fir_delay_chain #(.TAPS(TAP_NUM), .SW(SAMPLE_W)) u_chain (
    .clk_i      (iClk12M),
    .rst_i      (iRst),
    .shift_en_i (state_q == SHIFT),
    .sample_i   (sample_q),
    .chain_o    (oDelay)
  );

`ifdef FIR_OVERRUN_CNT_EN
  logic [OVR_W-1:0] ovr_q;

  always_ff @(posedge iClk12M) begin
    if (iRst)
      ovr_q <= '0;
    else if (iEnSample && (state_q != IDLE) && (ovr_q != {OVR_W{1'b1}}))
      ovr_q <= ovr_q + OVR_W'(1);
  end

  assign oOverrun = ovr_q;
`endif

  assign oCsn      = csn_q;
  assign oAddr     = addr_q;
  assign oEnMul    = mul_q;
  assign oEnAddAcc = mul_q;
  assign oFirOut   = fir_q;
  assign oValid    = valid_q;
  assign oBusy     = busy_q;
endmodule
